// File: rtl/decode_stage.sv
// LC-3 decode stage: registers the fetched instruction and NPC and derives the
// execute, writeback and memory control words, the instruction class and an illegal flag.
module decode_stage #(
    parameter int              DATA_WIDTH = 16,
    parameter int              ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_NPC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_decode,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic [ADDR_WIDTH-1:0] npc_in,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [ADDR_WIDTH-1:0] npc_out,
    output logic [5:0]            e_control,
    output logic [1:0]            w_control,
    output logic                  mem_control,
    output logic [1:0]            instr_class,
    output logic                  illegal_op,
    output logic                  decode_valid
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PC1_OFF11 = 2'b00;
    localparam logic [1:0] PC1_OFF9  = 2'b01;
    localparam logic [1:0] PC1_OFF6  = 2'b10;
    localparam logic [1:0] PC1_ZERO  = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam logic [1:0] CLS_ALU   = 2'b00;
    localparam logic [1:0] CLS_CTRL  = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    logic [3:0] opcode;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic [1:0] alu_control;
    logic       op2select;
    logic [1:0] w_next;
    logic       mem_next;
    logic [1:0] class_next;
    logic       illegal_next;

    assign opcode = dout[15:12];

    always_comb begin
        pcselect1    = PC1_OFF11;
        pcselect2    = 1'b0;
        alu_control  = ALU_ADD;
        op2select    = 1'b0;
        w_next       = WB_ALU;
        mem_next     = 1'b0;
        class_next   = CLS_ALU;
        illegal_next = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                alu_control = ALU_ADD;
                op2select   = ~dout[5];
            end
            OP_AND: begin
                alu_control = ALU_AND;
                op2select   = ~dout[5];
            end
            OP_NOT: alu_control = ALU_NOT;
            OP_BR: begin
                pcselect1  = PC1_OFF9;
                pcselect2  = 1'b1;
                class_next = CLS_CTRL;
            end
            OP_JMP: begin
                pcselect1  = PC1_ZERO;
                class_next = CLS_CTRL;
            end
            OP_LD, OP_LDI: begin
                pcselect1  = PC1_OFF9;
                pcselect2  = 1'b1;
                w_next     = WB_MEM;
                mem_next   = (opcode == OP_LDI);
                class_next = CLS_LOAD;
            end
            OP_LDR: begin
                pcselect1  = PC1_OFF6;
                w_next     = WB_MEM;
                class_next = CLS_LOAD;
            end
            OP_LEA: begin
                pcselect1 = PC1_OFF9;
                pcselect2 = 1'b1;
                w_next    = WB_PC;
            end
            OP_ST, OP_STI: begin
                pcselect1  = PC1_OFF9;
                pcselect2  = 1'b1;
                mem_next   = (opcode == OP_STI);
                class_next = CLS_STORE;
            end
            OP_STR: begin
                pcselect1  = PC1_OFF6;
                class_next = CLS_STORE;
            end
            // JSR, RTI, reserved and TRAP are not handled by this pipeline
            default: illegal_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ir           <= '0;
            npc_out      <= RESET_NPC;
            e_control    <= '0;
            w_control    <= '0;
            mem_control  <= 1'b0;
            instr_class  <= '0;
            illegal_op   <= 1'b0;
            decode_valid <= 1'b0;
        end else begin
            decode_valid <= enable_decode;
            if (enable_decode) begin
                ir          <= dout;
                npc_out     <= npc_in;
                e_control   <= {pcselect1, pcselect2, alu_control, op2select};
                w_control   <= w_next;
                mem_control <= mem_next;
                instr_class <= class_next;
                illegal_op  <= illegal_next;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-computed expectations,
// a monitor pops and compares whenever decode_valid is presented.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] ir;
    logic [15:0] npc_out;
    logic [5:0]  e_control;
    logic [1:0]  w_control;
    logic        mem_control;
    logic [1:0]  instr_class;
    logic        illegal_op;
    logic        decode_valid;

    int errors = 0;
    int checks = 0;
    int popped = 0;
    int pushed = 0;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        mem;
        logic [1:0]  cls;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .ir            (ir),
        .npc_out       (npc_out),
        .e_control     (e_control),
        .w_control     (w_control),
        .mem_control   (mem_control),
        .instr_class   (instr_class),
        .illegal_op    (illegal_op),
        .decode_valid  (decode_valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t o;
        o = '{ir: ir, npc: npc_out, e: e_control, w: w_control,
              mem: mem_control, cls: instr_class, ill: illegal_op};
        return o;
    endfunction

    always @(posedge clk) begin
        #1;
        if (decode_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: decode_valid=1 got ir=%h but no capture was issued", ir);
            end else begin
                exp_t e;
                exp_t o;
                e = sb.pop_front();
                popped++;
                o = observed();
                if (o !== e) begin
                    errors++;
                    $display("FAIL capture[%0d]: got ir=%h npc=%h e=%b w=%b mem=%b cls=%b ill=%b, exp ir=%h npc=%h e=%b w=%b mem=%b cls=%b ill=%b",
                             popped, o.ir, o.npc, o.e, o.w, o.mem, o.cls, o.ill,
                             e.ir, e.npc, e.e, e.w, e.mem, e.cls, e.ill);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] d, input logic [15:0] n, input logic [5:0] e,
                         input logic [1:0] w, input logic m, input logic [1:0] c, input logic il);
        @(negedge clk);
        reset         = 1'b1;
        enable_decode = 1'b1;
        dout          = d;
        npc_in        = n;
        sb.push_back('{ir: d, npc: n, e: e, w: w, mem: m, cls: c, ill: il});
        pushed++;
    endtask

    task automatic check_reset_values(input string name);
        exp_t o;
        @(posedge clk);
        #1;
        o = observed();
        checks++;
        if (o !== '0 || decode_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ir=%h npc=%h e=%b w=%b mem=%b cls=%b ill=%b dv=%b, exp all zero",
                     name, o.ir, o.npc, o.e, o.w, o.mem, o.cls, o.ill, decode_valid);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable_decode = 1'b0;
            dout          = 16'hxxxx;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        enable_decode = 1'b1;
        dout          = 16'h1042;
        npc_in        = 16'h3001;
        check_reset_values("reset_cycle1");
        check_reset_values("reset_cycle2");

        issue(16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0, 2'b00, 1'b0); // ADD reg
        issue(16'h2205, 16'h3002, 6'b011000, 2'b01, 1'b0, 2'b10, 1'b0); // LD
        issue(16'hA205, 16'h3003, 6'b011000, 2'b01, 1'b1, 2'b10, 1'b0); // LDI
        issue(16'h7283, 16'h3004, 6'b100000, 2'b00, 1'b0, 2'b11, 1'b0); // STR
        issue(16'h5025, 16'h3005, 6'b000010, 2'b00, 1'b0, 2'b00, 1'b0); // AND imm
        idle(1);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (e_control !== 6'b000010 || ir !== 16'h5025 || npc_out !== 16'h3005 || decode_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got ir=%h npc=%h e=%b dv=%b, exp ir=5025 npc=3005 e=000010 dv=0",
                         i, ir, npc_out, e_control, decode_valid);
            end
            if (i < 3) idle(1);
            @(posedge clk);
        end

        issue(16'hF025, 16'h4000, 6'b000000, 2'b00, 1'b0, 2'b00, 1'b1); // TRAP
        issue(16'hE1FF, 16'h4001, 6'b011000, 2'b10, 1'b0, 2'b00, 1'b0); // LEA
        issue(16'h927F, 16'h4002, 6'b000100, 2'b00, 1'b0, 2'b00, 1'b0); // NOT
        issue(16'h0E05, 16'h4003, 6'b011000, 2'b00, 1'b0, 2'b01, 1'b0); // BR
        issue(16'h6283, 16'h4004, 6'b100000, 2'b01, 1'b0, 2'b10, 1'b0); // LDR
        issue(16'h3205, 16'h4005, 6'b011000, 2'b00, 1'b0, 2'b11, 1'b0); // ST
        issue(16'hB205, 16'h4006, 6'b011000, 2'b00, 1'b1, 2'b11, 1'b0); // STI
        issue(16'h1160, 16'hFFFF, 6'b000000, 2'b00, 1'b0, 2'b00, 1'b0); // ADD imm, npc max
        issue(16'h4800, 16'h4008, 6'b000000, 2'b00, 1'b0, 2'b00, 1'b1); // JSR
        issue(16'h8000, 16'h4009, 6'b000000, 2'b00, 1'b0, 2'b00, 1'b1); // RTI
        issue(16'hD123, 16'h400A, 6'b000000, 2'b00, 1'b0, 2'b00, 1'b1); // reserved
        @(posedge clk);

        // reset and enable on the same edge: reset wins, nothing queued
        @(negedge clk);
        reset         = 1'b0;
        enable_decode = 1'b1;
        dout          = 16'hC1C0;
        npc_in        = 16'h5000;
        check_reset_values("reset_over_enable");

        issue(16'hC1C0, 16'h5000, 6'b110000, 2'b00, 1'b0, 2'b01, 1'b0); // JMP
        @(posedge clk);
        idle(3);
        @(posedge clk);
        #2;

        checks++;
        if (sb.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain: got popped=%0d left=%0d, exp popped=%0d left=0", popped, sb.size(), pushed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
